// File: rtl/ring_fifo.sv
// Circular-buffer FIFO for any DEPTH >= 2 (power of two not required).
// Supports a registered-read mode and a first-word-fall-through mode.
module ring_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 20,
   parameter bit FWFT      = 1'b0,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       valid,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp, rp, wp_nxt, rp_nxt;
   logic [CW-1:0]    count_nxt, cnt_after_rd;
   logic             rd_acc, wr_acc;
   logic [WIDTH-1:0] head_nxt;

   // A read frees a slot, so a full FIFO may still accept a write in the same cycle.
   always_comb begin
      rd_acc       = rd_en && !empty;
      wr_acc       = wr_en && (!full || rd_acc);
      wp_nxt       = wp;
      rp_nxt       = rp;
      if (wr_acc) wp_nxt = (wp == LAST_PTR) ? '0 : wp + 1'b1;
      if (rd_acc) rp_nxt = (rp == LAST_PTR) ? '0 : rp + 1'b1;
      cnt_after_rd = count - {{(CW-1){1'b0}}, rd_acc};
      count_nxt    = cnt_after_rd + {{(CW-1){1'b0}}, wr_acc};
      head_nxt     = dout;
      if (cnt_after_rd != '0)
         head_nxt = mem[rp_nxt];
      else if (wr_acc)
         head_nxt = din;
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wp] <= din;
   end

   // Flags are derived from the next count so they always agree with count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp          <= '0;
         rp          <= '0;
         count       <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
         valid       <= 1'b0;
         dout        <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         wp          <= wp_nxt;
         rp          <= rp_nxt;
         count       <= count_nxt;
         empty       <= (count_nxt == '0);
         full        <= (count_nxt == DEPTH_CNT);
         almost_full <= (count_nxt >= AFULL_CNT);
         overflow    <= wr_en && full && !rd_acc;
         underflow   <= rd_en && empty;
         if (FWFT) begin
            valid <= (count_nxt != '0);
            dout  <= head_nxt;
         end else begin
            valid <= rd_acc;
            if (rd_acc) dout <= mem[rp];
         end
      end
   end

endmodule

// File: doc/ring_fifo.md
RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 The module SHALL expose parameters, one per line:
- WIDTH, 8: data width in bits.
- DEPTH, 20: number of entries, any integer >= 2, not necessarily a power of two.
- FWFT, 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
- AFULL_LVL, DEPTH-2: count at or above which almost_full asserts.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The module SHALL expose ports, one per line:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- wr_en, input, 1: write request.
- din, input, WIDTH: write data.
- rd_en, input, 1: read/pop request.
- dout, output, WIDTH: read data.
- valid, output, 1: dout holds valid data.
- empty, output, 1: no entries stored.
- full, output, 1: count == DEPTH.
- almost_full, output, 1: count >= AFULL_LVL.
- count, output, $clog2(DEPTH+1): current occupancy.
- overflow, output, 1: one-cycle pulse when a write is dropped.
- underflow, output, 1: one-cycle pulse when a read is rejected.

Function
REQ-004 Storage SHALL be a DEPTH-entry circular buffer with write pointer wp and read pointer rp, each in range 0..DEPTH-1.
REQ-005 Each pointer SHALL wrap from DEPTH-1 to 0 by explicit compare, never by power-of-two truncation.
REQ-006 A write SHALL be accepted when wr_en=1 and (full=0 or an accepted read occurs in the same cycle): mem[wp] <= din, wp advances.
REQ-007 A write with wr_en=1, full=1 and no accepted read SHALL be dropped, leave all state unchanged, and pulse overflow for exactly one cycle.
REQ-008 A read SHALL be accepted when rd_en=1 and empty=0; rp advances.
REQ-009 rd_en=1 with empty=1 SHALL be rejected, pulse underflow for one cycle, and leave pointers/count unchanged, even if wr_en=1 in the same cycle.
REQ-010 count SHALL update on the clock edge: +1 for a write alone, -1 for a read alone, unchanged for a simultaneous accepted read and write.
REQ-011 empty, full and almost_full SHALL be registered and consistent with the count value of the same cycle.
REQ-012 With FWFT=0, an accepted read SHALL drive dout <= mem[rp] and valid=1 in the following cycle only; valid SHALL be 0 otherwise and dout SHALL hold its last value.
REQ-013 With FWFT=1, dout SHALL show mem[rp] whenever empty=0, and valid SHALL equal ~empty; an accepted read pops the entry and dout shows the next entry in the following cycle.
REQ-014 With FWFT=1, a write into an empty FIFO SHALL make valid=1 and dout=din in the cycle after the write edge (one-cycle latency).
REQ-015 In both modes, data SHALL leave in strict write order across pointer wrap.
REQ-016 overflow and underflow SHALL both be able to pulse in the same cycle only if their individual conditions are independently met.

Reset
REQ-017 On rst=1, asynchronously and regardless of clk, the module SHALL force: wp=0, rp=0, count=0, empty=1, full=0, almost_full=0, valid=0, dout=0, overflow=0, underflow=0.
REQ-018 Memory contents SHALL NOT be cleared by reset and SHALL never be observable after reset without a new write.
REQ-019 Reset asserted mid-transfer SHALL discard all stored entries; the first read after release SHALL return the first word written after release.

Verification
REQ-020 Scenario -- fill and drain, FWFT=0, DEPTH=20: write 0x01..0x14 -> full=1 and count=20 after the 20th edge; 20 reads -> dout 0x01..0x14, each with a one-cycle valid; then empty=1.
REQ-021 Scenario -- wrap: write 15, read 15, write 10, read 10 -> data order preserved; wp and rp pass 19->0 with no lost or duplicated word.
REQ-022 Scenario -- full boundary: with count=20, wr_en alone -> overflow=1 for one cycle, count stays 20; wr_en+rd_en together -> both accepted, count stays 20, and the new word appears 20 reads later.
REQ-023 Scenario -- empty boundary: rd_en with empty=1 -> underflow=1, valid=0; rd_en+wr_en on empty -> write accepted, underflow=1, count=1.
REQ-024 Scenario -- FWFT=1: write 0xA5 to empty -> next cycle valid=1, dout=0xA5 with no rd_en; pop -> valid=0, empty=1.
REQ-025 Scenario -- async reset: with count=7, assert rst between clock edges -> all outputs take reset values immediately; write 0x3C after release -> first read returns 0x3C.
